video_frame_ctrl: RTL

Frame/line sequencer for the HDMI input video stream. It sits between the HDMI receiver timing outputs (de/hs/vs/rgb) and the pixel-processing datapath. It registers and delays the timing signals, generates pixel coordinates and frame/line markers, and holds a double-buffered region-of-interest (ROI) configuration that switches only at frame boundaries. It also checks each frame's geometry against the expected resolution and reports per-frame status.

---
 rtl/video_frame_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/video_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : video_frame_ctrl
// Desc     : HDMI input frame/line sequencer. Delays de/hs/vs by two cycles,
//            generates pixel coordinates, sof/eol markers and an ROI flag from
//            a double-buffered configuration that switches at frame
//            boundaries, and reports per-frame geometry status.
// Revision : 1.0 - initial release
// ============================================================================
module video_frame_ctrl #(
  parameter int XW    = 11,
  parameter int YW    = 11,
  parameter int H_RES = 64,
  parameter int V_RES = 64,
  parameter int FCW   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           de_in,
  input  logic           hs_in,
  input  logic           vs_in,
  input  logic           cfg_wr,
  input  logic [XW-1:0]  cfg_x0,
  input  logic [XW-1:0]  cfg_x1,
  input  logic [YW-1:0]  cfg_y0,
  input  logic [YW-1:0]  cfg_y1,
  output logic           cfg_pending,
  output logic           de_out,
  output logic           hs_out,
  output logic           vs_out,
  output logic [XW-1:0]  x,
  output logic [YW-1:0]  y,
  output logic           sof,
  output logic           eol,
  output logic           roi,
  output logic           frame_err,
  output logic [FCW-1:0] frame_cnt
);

  localparam logic [XW-1:0] c_x_max = '1;
  localparam logic [YW-1:0] c_y_max = '1;
  localparam logic [XW:0]   c_h_res = (XW+1)'(H_RES);
  localparam logic [YW:0]   c_v_res = (YW+1)'(V_RES);

  // Stage 1: raw timing registers; stage 2: everything visible on the ports
  logic           r_de_s1, r_hs_s1, r_vs_s1;
  logic           r_de_s2, r_hs_s2, r_vs_s2;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic           r_sof, r_eol, r_roi;
  logic           r_synced;
  logic           r_pending;
  logic [XW-1:0]  r_sh_x0, r_sh_x1, r_act_x0, r_act_x1;
  logic [YW-1:0]  r_sh_y0, r_sh_y1, r_act_y0, r_act_y1;
  logic           r_line_bad;
  logic           r_frame_err;
  logic [FCW-1:0] r_frame_cnt;

  logic           w_fb;
  logic           w_de_fall;
  logic           w_synced_nxt;
  logic [XW-1:0]  w_x_nxt;
  logic [YW-1:0]  w_y_nxt;
  logic [XW-1:0]  w_ax0, w_ax1;
  logic [YW-1:0]  w_ay0, w_ay1;
  logic           w_in_roi;
  logic [XW:0]    w_line_len;

  // Frame boundary is the vs rising edge seen at stage 1 (r_vs_s2 holds its previous value)
  assign w_fb         = r_vs_s1 & ~r_vs_s2;
  // Line end: the pixel now at stage 2 was the last one of its line
  assign w_de_fall    = r_de_s2 & ~r_de_s1;
  assign w_synced_nxt = r_synced | w_fb;
  // r_x still holds the column of the last pixel, so length is one more
  assign w_line_len   = {1'b0, r_x} + (XW+1)'(1);

  // The pixel entering stage 2 on an FB is judged against the config loaded by that FB
  assign w_ax0 = (w_fb && r_pending) ? r_sh_x0 : r_act_x0;
  assign w_ax1 = (w_fb && r_pending) ? r_sh_x1 : r_act_x1;
  assign w_ay0 = (w_fb && r_pending) ? r_sh_y0 : r_act_y0;
  assign w_ay1 = (w_fb && r_pending) ? r_sh_y1 : r_act_y1;

  assign w_in_roi = (w_x_nxt >= w_ax0) && (w_x_nxt <= w_ax1) &&
                    (w_y_nxt >= w_ay0) && (w_y_nxt <= w_ay1);

  // Next coordinates for the stage-1 pixel; FB wins over line and pixel stepping
  always_comb begin
    w_x_nxt = '0;
    w_y_nxt = r_y;
    if (w_fb) begin
      w_x_nxt = '0;
      w_y_nxt = '0;
    end else begin
      if (r_de_s1 && r_de_s2) begin
        w_x_nxt = (r_x == c_x_max) ? r_x : r_x + XW'(1);
      end
      if (w_de_fall) begin
        w_y_nxt = (r_y == c_y_max) ? r_y : r_y + YW'(1);
      end
    end
  end

  // Stage 1: capture the HDMI timing inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de_s1 <= 1'b0;
      r_hs_s1 <= 1'b0;
      r_vs_s1 <= 1'b0;
    end else begin
      r_de_s1 <= de_in;
      r_hs_s1 <= hs_in;
      r_vs_s1 <= vs_in;
    end
  end

  // Stage 2: delayed timing, coordinates and per-pixel markers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de_s2  <= 1'b0;
      r_hs_s2  <= 1'b0;
      r_vs_s2  <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_sof    <= 1'b0;
      r_eol    <= 1'b0;
      r_roi    <= 1'b0;
      r_synced <= 1'b0;
    end else begin
      r_de_s2  <= r_de_s1;
      r_hs_s2  <= r_hs_s1;
      r_vs_s2  <= r_vs_s1;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_sof    <= r_de_s1 & w_synced_nxt & (w_x_nxt == '0) & (w_y_nxt == '0);
      r_eol    <= r_de_s1 & ~de_in;
      r_roi    <= r_de_s1 & w_synced_nxt & w_in_roi;
      r_synced <= w_synced_nxt;
    end
  end

  // ROI shadow/active double buffer; a write in the FB cycle lands in shadow after the swap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_sh_x0   <= '0;
      r_sh_x1   <= '0;
      r_sh_y0   <= '0;
      r_sh_y1   <= '0;
      r_act_x0  <= '0;
      r_act_x1  <= '0;
      r_act_y0  <= '0;
      r_act_y1  <= '0;
    end else begin
      if (w_fb && r_pending) begin
        r_act_x0 <= r_sh_x0;
        r_act_x1 <= r_sh_x1;
        r_act_y0 <= r_sh_y0;
        r_act_y1 <= r_sh_y1;
      end
      if (cfg_wr) begin
        r_sh_x0   <= cfg_x0;
        r_sh_x1   <= cfg_x1;
        r_sh_y0   <= cfg_y0;
        r_sh_y1   <= cfg_y1;
        r_pending <= 1'b1;
      end else if (w_fb) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Geometry check: sticky bad-line flag, frame status latched at each synced FB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_bad  <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_fb) begin
        if (r_synced) begin
          r_frame_err <= r_line_bad | ({1'b0, r_y} != c_v_res);
          r_frame_cnt <= r_frame_cnt + FCW'(1);
        end
        r_line_bad <= 1'b0;
      end else if (w_de_fall && (w_line_len != c_h_res)) begin
        r_line_bad <= 1'b1;
      end
    end
  end

  assign cfg_pending = r_pending;
  assign de_out      = r_de_s2;
  assign hs_out      = r_hs_s2;
  assign vs_out      = r_vs_s2;
  assign x           = r_x;
  assign y           = r_y;
  assign sof         = r_sof;
  assign eol         = r_eol;
  assign roi         = r_roi;
  assign frame_err   = r_frame_err;
  assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire
